// File: rtl/div32_pkg.sv
// Shared definitions for the 32-bit restoring divider.
// Holds the operand width, the number of restoring iterations,
// the last value of the iteration counter, the quotient returned
// on divide-by-zero, and the controller state type.
package div32_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int ITERATIONS = 32;

  // The 5-bit iteration counter runs 0..31, one value per restoring step.
  localparam logic [4:0] LAST_COUNT = 5'(ITERATIONS - 1);

  // Divide-by-zero returns an all-ones quotient regardless of signedness.
  localparam logic [DIV_WIDTH-1:0] DBZ_QUO = '1;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    ITER,
    POST
  } state_t;

endpackage

// File: rtl/cond_neg32.sv
// Conditional two's-complement negate.
// Ports:
//   din  - 32-bit value
//   neg  - 1 = negate din, 0 = pass din unchanged
//   dout - din when neg=0, -din when neg=1
module cond_neg32 (
  input  logic [31:0] din,
  input  logic        neg,
  output logic [31:0] dout
);

  // XOR with the control bit broadcast gives the one's complement only
  // when neg=1; adding neg then completes the two's-complement negate.
  assign dout = (din ^ {32{neg}}) + {31'd0, neg};

endmodule

// File: rtl/div32_ctrl.sv
// Multi-cycle signed/unsigned 32-bit divider controller.
// One restoring step per clock; operands are converted to magnitudes
// first and the signs are patched back onto the result afterwards.
// Ports:
//   clk, rst_n   - clock and asynchronous active-low reset
//   start        - request a division (only honoured when idle)
//   sgn          - 1 = signed two's-complement operands, 0 = unsigned
//   a, b         - dividend and divisor, captured together with start
//   busy         - high while an operation is in flight
//   done         - one-cycle pulse when quo/rem/div_by_zero update
//   quo, rem     - quotient and remainder of the last completed operation
//   div_by_zero  - the last completed operation had a zero divisor
module div32_ctrl
  import div32_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);

  state_t           state;
  logic [4:0]       count;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic             sgnreg;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] remw;
  logic [WIDTH-1:0] quow;

  logic [WIDTH-1:0] nega_in;
  logic             nega_ctl;
  logic [WIDTH-1:0] nega_out;
  logic [WIDTH-1:0] negb_in;
  logic             negb_ctl;
  logic [WIDTH-1:0] negb_out;

  logic [WIDTH-1:0] shifted_rem;
  logic [WIDTH-1:0] diff;
  logic             carry;
  logic             take;

  // The two negators are shared between PRE and POST. In PRE they turn
  // the captured operands into magnitudes; in POST they restore the sign
  // of the quotient (negative when the operand signs differ) and of the
  // remainder (which follows the dividend).
  always_comb begin
    nega_in  = areg;
    nega_ctl = sgnreg & areg[WIDTH-1];
    negb_in  = breg;
    negb_ctl = sgnreg & breg[WIDTH-1];
    if (state == POST) begin
      nega_in  = quow;
      nega_ctl = sgnreg & (areg[WIDTH-1] ^ breg[WIDTH-1]);
      negb_in  = remw;
      negb_ctl = sgnreg & areg[WIDTH-1];
    end
  end

  cond_neg32 u_nega (
    .din  (nega_in),
    .neg  (nega_ctl),
    .dout (nega_out)
  );

  cond_neg32 u_negb (
    .din  (negb_in),
    .neg  (negb_ctl),
    .dout (negb_out)
  );

  // One restoring step. The shifted partial remainder is really 33 bits
  // wide: its top bit is remw's MSB. When that bit is set the partial
  // remainder is at least 2^32 and the subtraction always succeeds, and
  // the low 32 bits of the difference are still exact. Otherwise the
  // carry out of (x + ~divisor + 1) means no borrow, i.e. x >= divisor.
  always_comb begin
    shifted_rem    = {remw[WIDTH-2:0], quow[WIDTH-1]};
    {carry, diff}  = {1'b0, shifted_rem} + {1'b0, ~divisor} + {{WIDTH{1'b0}}, 1'b1};
    take           = remw[WIDTH-1] | carry;
  end

  // Controller and datapath registers. done defaults low every cycle so
  // the POST transition yields a single-cycle pulse. Result outputs are
  // written only in POST so they hold between completions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      areg        <= '0;
      breg        <= '0;
      sgnreg      <= 1'b0;
      divisor     <= '0;
      remw        <= '0;
      quow        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quo         <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            areg   <= a;
            breg   <= b;
            sgnreg <= sgn;
            busy   <= 1'b1;
            state  <= PRE;
          end
        end
        PRE: begin
          quow    <= nega_out;
          divisor <= negb_out;
          remw    <= '0;
          count   <= '0;
          state   <= (breg == '0) ? POST : ITER;
        end
        ITER: begin
          remw <= take ? diff : shifted_rem;
          quow <= {quow[WIDTH-2:0], take};
          if (count == LAST_COUNT) begin
            state <= POST;
          end else begin
            count <= count + 5'd1;
          end
        end
        POST: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          if (breg == '0) begin
            quo         <= DBZ_QUO;
            rem         <= areg;
            div_by_zero <= 1'b1;
          end else begin
            quo         <= nega_out;
            rem         <= negb_out;
            div_by_zero <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
